// File: rtl/rand_gen_pkg.sv
// Shared constants and the xorshift32 step function for the rand_gen32 generator.
package rand_gen_pkg;

  localparam int          SHIFT_A      = 13;
  localparam int          SHIFT_B      = 17;
  localparam int          SHIFT_C      = 5;
  localparam logic [31:0] WEYL_INC     = 32'h9E37_79B9;
  localparam logic [31:0] DEFAULT_SEED = 32'hDEAD_BEEF;

  // One xorshift32 advance; logical shifts, bits shifted out are dropped.
  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = s ^ (s << SHIFT_A);
    t2 = t1 ^ (t1 >> SHIFT_B);
    return t2 ^ (t2 << SHIFT_C);
  endfunction

endpackage

// File: rtl/xorshift32_step.sv
// Purely combinational xorshift32 step: three shift/XOR stages, 32-bit in, 32-bit out.
module xorshift32_step
  import rand_gen_pkg::*;
(
  input  logic [31:0] s,
  output logic [31:0] next
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1   = s ^ (s << SHIFT_A);
  assign t2   = t1 ^ (t1 >> SHIFT_B);
  assign next = t2 ^ (t2 << SHIFT_C);

endmodule

// File: rtl/rand_gen32.sv
// Free-running xorshift32 pseudo-random generator, one new word per clock.
// Optional Weyl-sequence mixing on the output is enabled by defining RAND_GEN_WEYL_EN.
module rand_gen32
  import rand_gen_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rnd
);

  // A zero seed would lock xorshift at zero forever, so it is promoted to 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  // NOTE: the declaration initialiser is the configuration/power-up value, so the
  // generator is valid even if rst_n is never pulsed; the async reset reloads the same value.
  logic [31:0] state = SEED_EFF;
  logic [31:0] stepped;
  logic [31:0] state_next;

  xorshift32_step u_step (
    .s    (state),
    .next (stepped)
  );

  // Zero is only reachable by corruption; recover to the seed rather than stick.
  always_comb begin
    state_next = stepped;
    if (state == 32'd0) state_next = SEED_EFF;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEED_EFF;
    else        state <= state_next;
  end

`ifdef RAND_GEN_WEYL_EN
  logic [31:0] weyl = 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) weyl <= 32'd0;
    else        weyl <= weyl + WEYL_INC;
  end

  assign rnd = state + weyl;
`else
  assign rnd = state;
`endif

endmodule

// File: tb/tb_rand_gen32.sv
// Self-checking bench for rand_gen32: reset behaviour, known sequence, random mid-run resets,
// zero-seed promotion and a free-running instance, against an arithmetic reference model.
module tb_rand_gen32;
  import rand_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rst_n_idle = 1'b1;
  logic [31:0] rnd_one;
  logic [31:0] rnd_zero;
  logic [31:0] rnd_def;

  int compared = 0;
  int mismatched = 0;
  int edges = 0;

  rand_gen32 #(.SEED(32'd1)) dut_one (.clk(clk), .rst_n(rst_n), .rnd(rnd_one));
  rand_gen32 #(.SEED(32'd0)) dut_zero (.clk(clk), .rst_n(rst_n), .rnd(rnd_zero));
  rand_gen32 dut_def (.clk(clk), .rst_n(rst_n_idle), .rnd(rnd_def));

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  // Reference: shifts written as multiply/divide by powers of two, modulo 2^32.
  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] seed_eff);
    logic [31:0] t;
    if (s == 32'd0) return seed_eff;
    t = s ^ (s * 32'd8192);
    t = t ^ (t / 32'd131072);
    t = t ^ (t * 32'd32);
    return t;
  endfunction

  function automatic logic [31:0] weyl_of(input int n);
`ifdef RAND_GEN_WEYL_EN
    return 32'(n) * WEYL_INC;
`else
    return 32'(n) * 32'd0;
`endif
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] seed, input int n);
    logic [31:0] seed_eff;
    logic [31:0] s;
    seed_eff = (seed == 32'd0) ? 32'd1 : seed;
    s = seed_eff;
    for (int i = 0; i < n; i++) s = ref_step(s, seed_eff);
    return s + weyl_of(n);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] known [4];
    logic [31:0] prev;
    int          n;
    int          run_len;

    known[0] = 32'h0000_0001;
    known[1] = 32'd270369;
    known[2] = 32'd67634689;
    known[3] = 32'd2647435461;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("reset_async_seed1", rnd_one, 32'h0000_0001);
    check("reset_async_seed0", rnd_zero, 32'h0000_0001);

    // Reset held across a rising edge keeps the seed
    @(negedge clk);
    check("reset_hold_seed1", rnd_one, 32'h0000_0001);
    rst_n = 1'b1;

    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("known_seq1_%0d", k), rnd_one, known[k] + weyl_of(k));
      check($sformatf("known_seq0_%0d", k), rnd_zero, known[k] + weyl_of(k));
    end
    n = 3;

    // Random-length runs, each ending with a reset pulse placed between edges
    for (int ep = 0; ep < 4; ep++) begin
      run_len = $urandom_range(10, 50);
      for (int i = 0; i < run_len; i++) begin
        @(posedge clk);
        #1;
        n++;
        check($sformatf("run%0d_step%0d", ep, n), rnd_one, ref_word(32'd1, n));
      end
      @(negedge clk);
      #($urandom_range(1, 2));
      rst_n = 1'b0;
      #1;
      check($sformatf("midrun_reset%0d", ep), rnd_one, 32'h0000_0001);
      check($sformatf("midrun_reset0_%0d", ep), rnd_zero, 32'h0000_0001);
      #1 rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk);
        #1;
        check($sformatf("restart%0d_%0d", ep, k), rnd_one, known[k] + weyl_of(k));
      end
      n = 3;
    end

    // Free-running instance, never reset, tracked by edge count since time zero
    @(negedge clk);
    prev = rnd_def;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("free_model_%0d", edges), rnd_def, ref_word(DEFAULT_SEED, edges));
      check($sformatf("free_known_%0d", edges), {31'd0, $isunknown(rnd_def)}, 32'd0);
`ifndef RAND_GEN_WEYL_EN
      check($sformatf("free_nonzero_%0d", edges), {31'd0, rnd_def == 32'd0}, 32'd0);
      check($sformatf("free_changes_%0d", edges), {31'd0, rnd_def == prev}, 32'd0);
`endif
      prev = rnd_def;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
